mux_n_arb: RTL and testbench

MUX_N_ARB -- requirements
Module: mux_n_arb

---
 rtl/mux_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 26 ++
 rtl/mux_n_arb.sv | 83 ++++++++
 tb/tb_mux_n_arb.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-channel mux/arbiter.
package mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  // Channel index width: never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority search: first requester after ptr, wrapping around.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/mux_n_arb.sv
// N-channel valid/ready mux with a single registered output stage;
// channel chosen by explicit select or by round-robin arbitration.
module mux_n_arb
  import mux_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  parameter  int MODE  = MODE_SEL,
  localparam int IW    = idx_w(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [IW-1:0]      sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IW-1:0]      out_idx
);

  logic             load_en;
  logic             choice_ok;
  logic [IW-1:0]    choice;
  logic [WIDTH-1:0] choice_data;
  logic             xfer;

  // Reset gates load_en so no beat is accepted while rst_n is low.
  assign load_en = rst_n && (!out_valid || out_ready);

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [IW-1:0] ptr;
      logic          unused_sel;

      assign unused_sel = ^sel;

      rr_arbiter #(.N(N)) u_arb (
        .req       (in_valid),
        .ptr       (ptr),
        .gnt_valid (choice_ok),
        .gnt_idx   (choice)
      );

      always_ff @(posedge clk) begin
        if (!rst_n)    ptr <= IW'(N - 1);
        else if (xfer) ptr <= choice;
      end
    end else begin : g_sel
      assign choice    = sel;
      assign choice_ok = (int'(sel) < N);
    end
  endgenerate

  always_comb begin
    in_ready    = '0;
    choice_data = '0;
    for (int i = 0; i < N; i++) begin
      if (choice == IW'(i)) begin
        in_ready[i] = load_en && choice_ok;
        choice_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer = |(in_valid & in_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= choice_data;
      out_idx   <= choice;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_n_arb.sv
// Bench for mux_n_arb: select-mode table, round-robin and reset sequences,
// then randomized traffic against a rule-level reference model.
module tb_mux_n_arb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [1:0]   sel;
  logic         out_ready;

  logic [3:0]   in_ready_s, in_ready_r;
  logic [31:0]  od_s, od_r;
  logic         ov_s, ov_r;
  logic [1:0]   oi_s, oi_r;

  logic [95:0]  in_data3;
  logic [2:0]   in_valid3, in_ready3;
  logic [1:0]   sel3, oi3;
  logic         out_ready3, ov3;
  logic [31:0]  od3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_n_arb #(.WIDTH(32), .N(4), .MODE(0)) u_sel (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_s), .sel(sel), .out_data(od_s), .out_valid(ov_s),
    .out_ready(out_ready), .out_idx(oi_s));

  mux_n_arb #(.WIDTH(32), .N(4), .MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_r), .sel(sel), .out_data(od_r), .out_valid(ov_r),
    .out_ready(out_ready), .out_idx(oi_r));

  mux_n_arb #(.WIDTH(32), .N(3), .MODE(0)) u_sel3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .sel(sel3), .out_data(od3), .out_valid(ov3),
    .out_ready(out_ready3), .out_idx(oi3));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_data(input logic [31:0] w);
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = w + 32'(i);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  vld;
    logic        ordy;
    logic [31:0] w;
    logic [3:0]  rdy;
    logic        ov;
    logic [31:0] od;
    logic [1:0]  oi;
  } vec_t;

  vec_t tbl[10];

  // Reference model state: index 0 = select mode, 1 = round-robin.
  bit          m_ov[2];
  logic [31:0] m_od[2];
  int          m_oi[2];
  int          m_ptr[2];

  function automatic int model_choice(input int mode, input int ptr,
                                      input logic [3:0] vld, input int s);
    if (mode == 0) return s;
    for (int k = 1; k <= 4; k++)
      if (vld[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  initial begin
    int          exp_i;
    logic [3:0]  exp_rdy [2];
    int          ch      [2];
    logic [3:0]  act_rdy [2];
    logic [31:0] act_od  [2];
    logic        act_ov  [2];
    logic [1:0]  act_oi  [2];

    tbl[0] = '{2'd2, 4'b0100, 1'b1, 32'hDEADBEED, 4'b0100, 1'b1, 32'hDEADBEEF, 2'd2};
    tbl[1] = '{2'd1, 4'b0010, 1'b0, 32'h100,      4'b0000, 1'b1, 32'hDEADBEEF, 2'd2};
    tbl[2] = '{2'd1, 4'b0010, 1'b0, 32'h100,      4'b0000, 1'b1, 32'hDEADBEEF, 2'd2};
    tbl[3] = '{2'd1, 4'b0010, 1'b0, 32'h100,      4'b0000, 1'b1, 32'hDEADBEEF, 2'd2};
    tbl[4] = '{2'd1, 4'b0010, 1'b1, 32'h100,      4'b0010, 1'b1, 32'h101,      2'd1};
    tbl[5] = '{2'd3, 4'b0000, 1'b1, 32'h200,      4'b1000, 1'b0, 32'h101,      2'd1};
    tbl[6] = '{2'd0, 4'b1111, 1'b0, 32'h300,      4'b0001, 1'b1, 32'h300,      2'd0};
    tbl[7] = '{2'd3, 4'b1000, 1'b0, 32'h400,      4'b0000, 1'b1, 32'h300,      2'd0};
    tbl[8] = '{2'd3, 4'b1000, 1'b1, 32'h400,      4'b1000, 1'b1, 32'h403,      2'd3};
    tbl[9] = '{2'd2, 4'b0100, 1'b1, 32'h500,      4'b0100, 1'b1, 32'h502,      2'd2};

    rst_n = 1'b0; in_valid = '1; sel = 2'd0; out_ready = 1'b1; set_data(32'h0);
    in_data3 = '0; in_valid3 = '0; sel3 = 2'd0; out_ready3 = 1'b1;

    // Reset: outputs cleared, nothing accepted while reset is held.
    tick();
    chk("rst_in_ready_sel", {60'd0, in_ready_s}, 64'd0);
    chk("rst_in_ready_rr",  {60'd0, in_ready_r}, 64'd0);
    tick();
    chk("rst_ov_sel", {63'd0, ov_s}, 64'd0);
    chk("rst_od_sel", {32'd0, od_s}, 64'd0);
    chk("rst_oi_sel", {62'd0, oi_s}, 64'd0);
    chk("rst_ov_rr",  {63'd0, ov_r}, 64'd0);

    rst_n = 1'b1;
    for (int r = 0; r < 10; r++) begin
      sel = tbl[r].sel; in_valid = tbl[r].vld; out_ready = tbl[r].ordy; set_data(tbl[r].w);
      #1;
      chk($sformatf("tbl%0d_in_ready", r), {60'd0, in_ready_s}, {60'd0, tbl[r].rdy});
      tick();
      chk($sformatf("tbl%0d_out_valid", r), {63'd0, ov_s}, {63'd0, tbl[r].ov});
      chk($sformatf("tbl%0d_out_data", r),  {32'd0, od_s}, {32'd0, tbl[r].od});
      chk($sformatf("tbl%0d_out_idx", r),   {62'd0, oi_s}, {62'd0, tbl[r].oi});
    end

    // Round-robin: fresh reset, then all channels requesting.
    rst_n = 1'b0; out_ready = 1'b0; tick();
    rst_n = 1'b1; out_ready = 1'b1; in_valid = 4'b1111; set_data(32'h1000);
    for (int k = 0; k < 5; k++) begin
      exp_i = k % 4;
      #1;
      chk($sformatf("rr_all%0d_in_ready", k), {60'd0, in_ready_r}, 64'd1 << exp_i);
      tick();
      chk($sformatf("rr_all%0d_out_idx", k), {62'd0, oi_r}, 64'(exp_i));
      chk($sformatf("rr_all%0d_out_data", k), {32'd0, od_r}, 64'(32'h1000 + exp_i));
      chk($sformatf("rr_all%0d_out_valid", k), {63'd0, ov_r}, 64'd1);
    end
    in_valid = 4'b0010; tick();
    chk("rr_ptr1_idx", {62'd0, oi_r}, 64'd1);
    in_valid = 4'b0001; #1;
    chk("rr_wrap_in_ready", {60'd0, in_ready_r}, 64'b0001);
    tick();
    chk("rr_wrap_idx", {62'd0, oi_r}, 64'd0);
    in_valid = 4'b1001; #1;
    chk("rr_next_in_ready", {60'd0, in_ready_r}, 64'b1000);
    tick();
    chk("rr_next_idx", {62'd0, oi_r}, 64'd3);

    // Reset while a beat is stalled in the output register.
    in_valid = 4'b0100; tick();
    chk("rr_pre_rst_idx", {62'd0, oi_r}, 64'd2);
    out_ready = 1'b0; in_valid = 4'b1111; #1;
    chk("rr_bp_in_ready", {60'd0, in_ready_r}, 64'd0);
    tick();
    chk("rr_bp_hold_valid", {63'd0, ov_r}, 64'd1);
    rst_n = 1'b0; #1;
    chk("rr_rst_in_ready", {60'd0, in_ready_r}, 64'd0);
    tick();
    chk("rr_rst_ov", {63'd0, ov_r}, 64'd0);
    chk("rr_rst_od", {32'd0, od_r}, 64'd0);
    chk("rr_rst_oi", {62'd0, oi_r}, 64'd0);
    rst_n = 1'b1; out_ready = 1'b1; set_data(32'h2000); #1;
    chk("rr_first_grant", {60'd0, in_ready_r}, 64'b0001);
    tick();
    chk("rr_first_idx", {62'd0, oi_r}, 64'd0);
    chk("rr_first_data", {32'd0, od_r}, 64'h2000);

    // N=3 select mode: out-of-range select accepts nothing.
    in_valid3 = 3'b111; out_ready3 = 1'b1; sel3 = 2'd3;
    in_data3 = {32'h33, 32'h22, 32'h11}; #1;
    chk("n3_sel3_in_ready", {61'd0, in_ready3}, 64'd0);
    tick();
    chk("n3_sel3_out_valid", {63'd0, ov3}, 64'd0);
    sel3 = 2'd2; #1;
    chk("n3_sel2_in_ready", {61'd0, in_ready3}, 64'b100);
    tick();
    chk("n3_sel2_out_data", {32'd0, od3}, 64'h33);
    chk("n3_sel2_out_idx", {62'd0, oi3}, 64'd2);

    // Randomized traffic on both N=4 instances.
    rst_n = 1'b0; tick();
    for (int m = 0; m < 2; m++) begin
      m_ov[m] = 1'b0; m_od[m] = '0; m_oi[m] = 0; m_ptr[m] = 3;
    end
    for (int c = 0; c < 400; c++) begin
      rst_n     = ($urandom_range(0, 39) != 0);
      in_valid  = 4'($urandom);
      sel       = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = $urandom;
      #1;
      act_rdy[0] = in_ready_s; act_rdy[1] = in_ready_r;
      for (int m = 0; m < 2; m++) begin
        exp_rdy[m] = '0;
        ch[m] = model_choice(m, m_ptr[m], in_valid, int'(sel));
        if (rst_n && (!m_ov[m] || out_ready) && ch[m] >= 0) exp_rdy[m][ch[m]] = 1'b1;
        chk($sformatf("rnd%0d_m%0d_in_ready", c, m), {60'd0, act_rdy[m]}, {60'd0, exp_rdy[m]});
        if (!rst_n) begin
          m_ov[m] = 1'b0; m_od[m] = '0; m_oi[m] = 0; m_ptr[m] = 3;
        end else if ((in_valid & exp_rdy[m]) != 0) begin
          m_ov[m] = 1'b1; m_od[m] = in_data[ch[m]*32 +: 32]; m_oi[m] = ch[m]; m_ptr[m] = ch[m];
        end else if (out_ready) begin
          m_ov[m] = 1'b0;
        end
      end
      tick();
      act_od[0] = od_s; act_od[1] = od_r;
      act_ov[0] = ov_s; act_ov[1] = ov_r;
      act_oi[0] = oi_s; act_oi[1] = oi_r;
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("rnd%0d_m%0d_out_valid", c, m), {63'd0, act_ov[m]}, {63'd0, m_ov[m]});
        chk($sformatf("rnd%0d_m%0d_out_data", c, m), {32'd0, act_od[m]}, {32'd0, m_od[m]});
        chk($sformatf("rnd%0d_m%0d_out_idx", c, m), {62'd0, act_oi[m]}, 64'(m_oi[m]));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
